spi_master_ctrl: RTL

Sequencing controller for the SPI master datapath. Accepts a one-word transfer request, drives chip select and the serial clock, and issues the per-bit strobes that the receive shift register (SIPO) and transmit shift register (PISO) consume. Sits between the host-side command interface and the shift-register datapath: one transfer per Start, with a one-cycle Done pulse at the end.

---
 rtl/spi_pkg.sv | 20 ++
 rtl/spi_master_ctrl_if.sv | 27 ++
 rtl/spi_clk_div.sv | 40 ++++
 rtl/spi_master_ctrl.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master sequencing controller.
package spi_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        XFER  = 3'd2,
        HOLD  = 3'd3,
        DONE  = 3'd4
    } spi_state_e;

    // SPI mode constants, encoded as {CPOL, CPHA}.
    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam logic [1:0] SPI_MODE1 = 2'b01;
    localparam logic [1:0] SPI_MODE2 = 2'b10;
    localparam logic [1:0] SPI_MODE3 = 2'b11;

endpackage

// File: rtl/spi_master_ctrl_if.sv
// Host/datapath-facing signal bundle of spi_master_ctrl.
// master: the controller side; slave: the host/datapath side.
interface spi_master_ctrl_if;

    logic Start;
    logic CPOL;
    logic CPHA;
    logic Busy;
    logic Done;
    logic CS_n;
    logic SCLK;
    logic EnSIPO;
    logic SCLKEdgeFlg;
    logic ShiftFlg;
    logic LoadPISO;

    modport master (
        input  Start, CPOL, CPHA,
        output Busy, Done, CS_n, SCLK, EnSIPO, SCLKEdgeFlg, ShiftFlg, LoadPISO
    );

    modport slave (
        output Start, CPOL, CPHA,
        input  Busy, Done, CS_n, SCLK, EnSIPO, SCLKEdgeFlg, ShiftFlg, LoadPISO
    );

endinterface

// File: rtl/spi_clk_div.sv
// Half-period counter for the SPI master: counts 0..ClkDiv-1 while enabled,
// flags the terminal count combinationally, clears synchronously.
module spi_clk_div #(
    parameter int unsigned ClkDiv = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic clr_i,
    output logic tc_c_o
);

    localparam int unsigned    CNT_W    = (ClkDiv > 1) ? $clog2(ClkDiv) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ClkDiv - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tc_c_o = en_i && (cnt_q == CNT_LAST);

    // Next count: clear wins, otherwise wrap at terminal count.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = tc_c_o ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI master sequencing controller: IDLE/SETUP/XFER/HOLD/DONE FSM, SCLK
// generation, edge counting and SIPO/PISO strobe decode.
// Optional feature macro: SPI_MODE_SEL_EN (honour CPOL/CPHA; otherwise mode 0).
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int unsigned WordLen = 8,
    parameter int unsigned ClkDiv  = 4
) (
    input  logic               clk,
    input  logic               rst,
    spi_master_ctrl_if.master  bus
);

    localparam int unsigned       EDGE_W    = $clog2(2 * WordLen) + 1;
    localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * WordLen - 1);

    spi_state_e        state_q, state_d;
    logic [EDGE_W-1:0] edge_cnt_q, edge_cnt_d;
    logic              cpha_q, cpha_d;
    logic              sclk_q, sclk_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              cs_n_q, cs_n_d;
    logic              en_sipo_q, en_sipo_d;

    logic [1:0]        mode_in_c;
    logic              run_c;
    logic              tc_c;
    logic              xfer_tc_c;
    logic              leading_c;
    logic              first_c;
    logic              last_c;
    logic              edge_flg_c;
    logic              shift_flg_c;
    logic              load_piso_c;

`ifdef SPI_MODE_SEL_EN
    assign mode_in_c = {bus.CPOL, bus.CPHA};
`else
    logic unused_mode_c;
    assign unused_mode_c = ^{bus.CPOL, bus.CPHA};
    assign mode_in_c     = SPI_MODE0;
`endif

    assign run_c = (state_q == SETUP) || (state_q == XFER) || (state_q == HOLD);

    spi_clk_div #(
        .ClkDiv (ClkDiv)
    ) u_clk_div (
        .clk    (clk),
        .rst    (rst),
        .en_i   (run_c),
        .clr_i  (!run_c),
        .tc_c_o (tc_c)
    );

    // Next state, edge count, latched phase and SCLK level.
    always_comb begin
        state_d    = state_q;
        edge_cnt_d = edge_cnt_q;
        cpha_d     = cpha_q;
        sclk_d     = sclk_q;
        unique case (state_q)
            IDLE: begin
                sclk_d     = mode_in_c[1];
                edge_cnt_d = '0;
                if (bus.Start) begin
                    state_d = SETUP;
                    cpha_d  = mode_in_c[0];
                end
            end
            SETUP: begin
                if (tc_c) state_d = XFER;
            end
            XFER: begin
                if (tc_c) begin
                    sclk_d     = !sclk_q;
                    edge_cnt_d = edge_cnt_q + EDGE_W'(1);
                    if (edge_cnt_q == EDGE_LAST) state_d = HOLD;
                end
            end
            HOLD: begin
                if (tc_c) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d    = (state_d == SETUP) || (state_d == XFER) || (state_d == HOLD);
        cs_n_d    = !busy_d;
        done_d    = (state_d == DONE);
        en_sipo_d = (state_d == XFER);
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            edge_cnt_q <= '0;
            cpha_q     <= 1'b0;
            sclk_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cs_n_q     <= 1'b1;
            en_sipo_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            edge_cnt_q <= edge_cnt_d;
            cpha_q     <= cpha_d;
            sclk_q     <= sclk_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            cs_n_q     <= cs_n_d;
            en_sipo_q  <= en_sipo_d;
        end
    end

    // Strobes fire in the terminal-count cycle, i.e. as SCLK is about to toggle.
    // edge_cnt_q counts toggles already made, so even values mean a leading edge.
    assign xfer_tc_c   = (state_q == XFER) && tc_c;
    assign leading_c   = !edge_cnt_q[0];
    assign first_c     = (edge_cnt_q == '0);
    assign last_c      = (edge_cnt_q == EDGE_LAST);
    assign edge_flg_c  = xfer_tc_c && (cpha_q ? !leading_c : leading_c);
    assign shift_flg_c = xfer_tc_c && (cpha_q ? (leading_c && !first_c)
                                              : (!leading_c && !last_c));
    assign load_piso_c = (state_q == IDLE) && bus.Start && !rst;

    assign bus.Busy        = busy_q;
    assign bus.Done        = done_q;
    assign bus.CS_n        = cs_n_q;
    assign bus.SCLK        = sclk_q;
    assign bus.EnSIPO      = en_sipo_q;
    assign bus.SCLKEdgeFlg = edge_flg_c;
    assign bus.ShiftFlg    = shift_flg_c;
    assign bus.LoadPISO    = load_piso_c;

endmodule
